accu: RTL and testbench



---
 rtl/accu_pkg.sv | 11 +
 rtl/accu_if.sv | 25 ++
 rtl/accu.sv | 44 ++++
 tb/tb_accu.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/accu_pkg.sv
// rtl/accu_pkg.sv - shared constants for the accumulator: default width and overflow-policy encodings
package accu_pkg;

    // Default operand / accumulator width.
    localparam int ACCU_WIDTH = 8;

    // Overflow policy encodings for the SATURATE parameter.
    localparam int ACCU_WRAP  = 0;    // keep low WIDTH bits of the sum
    localparam int ACCU_SAT   = 1;    // clamp at all-ones on carry out

endpackage : accu_pkg

// File: rtl/accu_if.sv
// rtl/accu_if.sv - operand/result bundle for an accu instance
//
// Signals:
//   in_data  : addend driven by the producer (master) into the accumulator
//   out_data : running sum driven by the accumulator (slave)
interface accu_if
    import accu_pkg::*;
#(
    parameter int WIDTH = ACCU_WIDTH
) ();

    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_data,
        input  out_data
    );

    modport slave (
        input  in_data,
        output out_data
    );

endinterface : accu_if

// File: rtl/accu.sv
// rtl/accu.sv - free-running unsigned accumulator with wrap or saturate overflow policy
//
// Ports (order fixed for positional instantiation):
//   in    : WIDTH-bit unsigned addend, sampled every rising clk edge
//   out   : WIDTH-bit accumulator value, straight from the register
//   clk   : rising-edge clock
//   reset : asynchronous active-high clear
module accu
    import accu_pkg::*;
#(
    parameter int WIDTH    = ACCU_WIDTH,
    parameter int SATURATE = ACCU_WRAP
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             reset
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   sum;

    // One extra bit so the carry out is visible to the clamp decision.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, in};
        if ((SATURATE == ACCU_SAT) && sum[WIDTH]) begin
            acc_d = '1;
        end else begin
            acc_d = sum[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign out = acc_q;

endmodule : accu

// File: tb/tb_accu.sv
// tb/tb_accu.sv - self-checking bench for accu, wrap and saturate instances side by side
module tb_accu;

    logic clk;
    logic reset;

    accu_if #(.WIDTH(8)) if_wrap ();
    accu_if #(.WIDTH(8)) if_sat  ();

    accu #(.WIDTH(8), .SATURATE(0)) u_wrap (
        .in    (if_wrap.in_data),
        .out   (if_wrap.out_data),
        .clk   (clk),
        .reset (reset)
    );

    accu #(.WIDTH(8), .SATURATE(1)) u_sat (
        .in    (if_sat.in_data),
        .out   (if_sat.out_data),
        .clk   (clk),
        .reset (reset)
    );

    int nvec;
    int nerr;

    // Reference sums held as plain integers.
    int model_wrap;
    int model_sat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: total of inputs mod 256 for wrap; running total capped at 255 for saturate.
    initial begin : compare
        model_wrap = 0;
        model_sat  = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_wrap = 0;
                model_sat  = 0;
            end else begin
                model_wrap = (model_wrap + int'(if_wrap.in_data)) % 256;
                model_sat  = model_sat + int'(if_sat.in_data);
                if (model_sat > 255) model_sat = 255;
            end
            #1;
            check("model_wrap", if_wrap.out_data, 8'(model_wrap));
            check("model_sat",  if_sat.out_data,  8'(model_sat));
        end
    end

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset pulse confined to the low phase of the clock.
    task automatic pulse_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b);
        if_wrap.in_data = a;
        if_sat.in_data  = b;
    endtask

    initial begin : stim
        logic [7:0] exp_w [5];
        logic [7:0] exp_s [5];
        nvec  = 0;
        nerr  = 0;
        reset = 1'b1;
        drive(8'd1, 8'd1);

        // Reset held across two edges, then constant input of 1.
        @(negedge clk);
        @(negedge clk);
        check("reset_wrap", if_wrap.out_data, 8'h00);
        check("reset_sat",  if_sat.out_data,  8'h00);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("count_up", if_wrap.out_data, 8'(k));
        end

        // Wrap and saturate on large addends.
        pulse_reset();
        drive(8'h80, 8'hC0);
        exp_w = '{8'h80, 8'h00, 8'h80, 8'h00, 8'h80};
        exp_s = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        for (int k = 0; k < 5; k++) begin
            step();
            check("wrap_80", if_wrap.out_data, exp_w[k]);
            check("sat_c0",  if_sat.out_data,  exp_s[k]);
        end

        // FF + 1 boundary.
        pulse_reset();
        drive(8'hFF, 8'hFF);
        step();
        check("load_ff_wrap", if_wrap.out_data, 8'hFF);
        check("load_ff_sat",  if_sat.out_data,  8'hFF);
        drive(8'h01, 8'h01);
        step();
        check("ff_plus1_wrap", if_wrap.out_data, 8'h00);
        check("ff_plus1_sat",  if_sat.out_data,  8'hFF);

        // F0 + 20 wraps to 10.
        pulse_reset();
        drive(8'hF0, 8'hF0);
        step();
        drive(8'h20, 8'h20);
        step();
        check("f0_20_wrap", if_wrap.out_data, 8'h10);
        check("f0_20_sat",  if_sat.out_data,  8'hFF);

        // Asynchronous reset mid-run.
        pulse_reset();
        drive(8'h01, 8'h01);
        for (int k = 0; k < 7; k++) step();
        check("count_7", if_wrap.out_data, 8'h07);
        #1 reset = 1'b1;
        #1;
        check("async_clr_wrap", if_wrap.out_data, 8'h00);
        check("async_clr_sat",  if_sat.out_data,  8'h00);
        #1 reset = 1'b0;
        step();
        check("resume_1", if_wrap.out_data, 8'h01);

        // Hold with zero addend.
        pulse_reset();
        drive(8'h2A, 8'h2A);
        step();
        drive(8'h00, 8'h00);
        for (int k = 0; k < 5; k++) begin
            step();
            check("hold_wrap", if_wrap.out_data, 8'h2A);
            check("hold_sat",  if_sat.out_data,  8'h2A);
        end

        // Random run; the compare process checks every edge.
        pulse_reset();
        for (int k = 0; k < 1000; k++) begin
            drive(8'($urandom), 8'($urandom_range(0, 3)));
            step();
        end

        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_accu
